// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers.
//   - state_e     : occupancy encoding of a pipe_skid_stage (value == count)
//   - *_bundle_t  : packed bundles carried between IF/ID/EX/MEM/WB
//   - *_WIDTH     : bundle widths, used to set WIDTH at instantiation
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Encoding doubles as the occupancy count driven on the count port.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // IF -> ID
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_bundle_t;

    // ID -> EX
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } de_bundle_t;

    // EX -> MEM
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } em_bundle_t;

    // MEM -> WB
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mw_bundle_t;

    localparam int FD_WIDTH = $bits(fd_bundle_t);
    localparam int DE_WIDTH = $bits(de_bundle_t);
    localparam int EM_WIDTH = $bits(em_bundle_t);
    localparam int MW_WIDTH = $bits(mw_bundle_t);

endpackage : pipe_pkg

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and an optional two-entry skid buffer.
//
// Parameters
//   WIDTH        width of the carried bundle
//   RESET_VALUE  value loaded into every data register on reset
//   SKID         1: main + skid register, in_ready is a flop
//                0: main register only, in_ready combinational from out_ready
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   flush                synchronous flush, drops every held bundle
//   in_valid/in_ready    upstream handshake, in_data upstream bundle
//   out_valid/out_ready  downstream handshake, out_data = main register
//   count                bundles currently held (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    if (SKID) begin : g_skid

        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_ready_q, in_ready_d;

        // NOTE: every variable gets its hold value first so no path through
        // the case leaves it unassigned; that is what keeps this a mux and
        // not a latch.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;

            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new bundle behind main.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase

            // Flush wins: handshakes still complete at the ports but the
            // bundles are dropped, and data registers are left untouched.
            if (flush) begin
                state_d = EMPTY;
                main_d  = main_q;
                skid_d  = skid_q;
            end

            // Registered ready: looks only at the next state, never at the
            // current inputs, so upstream sees no combinational path.
            in_ready_d = (state_d != FULL);
        end

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        // NOTE: the two data registers are reset as well, so out_data shows
        // RESET_VALUE after reset instead of X.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q    <= EMPTY;
                main_q     <= RESET_VALUE;
                skid_q     <= RESET_VALUE;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;

    end else begin : g_no_skid

        // Single register: can accept when empty or when it drains this cycle.
        assign in_ready = !out_valid || out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;

            if (in_fire) begin
                state_d = ONE;
                main_d  = in_data;
            end else if (out_fire) begin
                state_d = EMPTY;
            end

            if (flush) begin
                state_d = EMPTY;
                main_d  = main_q;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= EMPTY;
                main_q  <= RESET_VALUE;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
            end
        end

    end

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed bench for pipe_skid_stage: one SKID=1 instance and one SKID=0
// instance sharing clock and reset. Inputs change 1 time unit after the
// rising edge; outputs are sampled mid-cycle, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int          W      = 32;
    localparam logic [31:0] RV_SK  = 32'hDEAD_BEEF;
    localparam logic [31:0] RV_NSK = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset_n;

    // SKID=1 instance signals
    logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [1:0]   s_count;

    // SKID=0 instance signals
    logic         n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [W-1:0] n_in_data, n_out_data;
    logic [1:0]   n_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV_SK), .SKID(1'b1)) u_dut_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .count     (s_count)
    );

    pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV_NSK), .SKID(1'b0)) u_dut_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (n_flush),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .count     (n_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all observable state of the SKID=1 instance at once.
    task automatic check_s(input string tag, input logic v, input logic r,
                           input logic [1:0] c, input logic [31:0] d);
        check({tag, ".out_valid"}, 32'(s_out_valid), 32'(v));
        check({tag, ".in_ready"},  32'(s_in_ready),  32'(r));
        check({tag, ".count"},     32'(s_count),     32'(c));
        check({tag, ".out_data"},  s_out_data,       d);
    endtask

    initial begin
        reset_n     = 1'b0;
        s_flush     = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
        n_flush     = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_data = '0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        check_s("reset", 1'b0, 1'b1, 2'd0, RV_SK);
        check("reset0.out_valid", 32'(n_out_valid), 32'd0);
        check("reset0.in_ready",  32'(n_in_ready),  32'd1);
        check("reset0.count",     32'(n_count),     32'd0);
        check("reset0.out_data",  n_out_data,       RV_NSK);

        // ---------------- streaming, SKID=1 ----------------
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 32'h11;
        tick();
        check_s("stream11", 1'b1, 1'b1, 2'd1, 32'h11);
        s_in_data = 32'h22;
        tick();
        check_s("stream22", 1'b1, 1'b1, 2'd1, 32'h22);
        s_in_data = 32'h33;
        tick();
        check_s("stream33", 1'b1, 1'b1, 2'd1, 32'h33);
        s_in_valid = 1'b0;
        tick();
        check_s("stream_drain", 1'b0, 1'b1, 2'd0, 32'h33);

        // ---------------- back-pressure, SKID=1 ----------------
        s_in_valid = 1'b1;
        s_in_data  = 32'hA0;
        tick();
        check_s("bp_a0", 1'b1, 1'b1, 2'd1, 32'hA0);
        s_out_ready = 1'b0;           // dropped while A0 is presented
        s_in_data   = 32'hA1;
        tick();
        check_s("bp_full", 1'b1, 1'b0, 2'd2, 32'hA0);
        s_in_data = 32'hA2;           // held upstream
        tick();
        check_s("bp_hold", 1'b1, 1'b0, 2'd2, 32'hA0);
        s_out_ready = 1'b1;
        tick();                       // A0 delivered, A1 moves to main
        check_s("bp_a1", 1'b1, 1'b1, 2'd1, 32'hA1);
        tick();                       // A1 delivered, A2 accepted
        check_s("bp_a2", 1'b1, 1'b1, 2'd1, 32'hA2);
        s_in_valid = 1'b0;
        tick();                       // A2 delivered
        check_s("bp_drain", 1'b0, 1'b1, 2'd0, 32'hA2);

        // ---------------- flush while FULL ----------------
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hB0;
        tick();
        s_in_data = 32'hB1;
        tick();
        check_s("fl_full", 1'b1, 1'b0, 2'd2, 32'hB0);
        s_flush     = 1'b1;
        s_out_ready = 1'b1;
        s_in_data   = 32'hB2;
        tick();
        // main keeps B0: data registers hold across flush
        check_s("fl_after", 1'b0, 1'b1, 2'd0, 32'hB0);
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        tick();
        check_s("fl_idle", 1'b0, 1'b1, 2'd0, 32'hB0);

        // ---------------- async reset mid-FULL ----------------
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hC0;
        tick();
        s_in_data = 32'hC1;
        tick();
        check_s("rst_full", 1'b1, 1'b0, 2'd2, 32'hC0);
        s_in_valid = 1'b0;
        #2 reset_n = 1'b0;            // mid-cycle, no clock edge
        #1;
        check_s("rst_async", 1'b0, 1'b1, 2'd0, RV_SK);
        #1 reset_n = 1'b1;
        tick();
        check_s("rst_release", 1'b0, 1'b1, 2'd0, RV_SK);

        // ---------------- SKID=0 stall ----------------
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        n_in_data   = 32'h55;
        tick();
        check("nsk_load.out_data", n_out_data, 32'h55);
        check("nsk_load.count",    32'(n_count), 32'd1);
        n_out_ready = 1'b0;
        n_in_data   = 32'h66;
        #1;
        check("nsk_stall.in_ready", 32'(n_in_ready), 32'd0);
        tick();
        check("nsk_hold.out_data", n_out_data, 32'h55);
        check("nsk_hold.count",    32'(n_count), 32'd1);
        n_out_ready = 1'b1;
        #1;
        check("nsk_release.in_ready", 32'(n_in_ready), 32'd1);
        tick();
        check("nsk_both.out_data", n_out_data, 32'h66);
        check("nsk_both.count",    32'(n_count), 32'd1);
        n_in_valid = 1'b0;
        tick();
        check("nsk_drain.out_valid", 32'(n_out_valid), 32'd0);
        check("nsk_drain.count",     32'(n_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_pipe_skid_stage
